microcode_sequencer: RTL and testbench

- Sequences the BasicCPU microcode store and issues one 12-bit opcode at a time to the register/ALU datapath.
- Selects one of three microcode programs and patches the immediate argument field from the 9-bit argument word.
- Resolves skip-if opcodes using a condition result returned by the datapath.
- Sits between the top-level control (start/done handshake) and the datapath (valid/ready opcode stream).

---
 rtl/mcseq_pkg.sv | 95 +++++++++
 rtl/microcode_store.sv | 50 +++++
 rtl/microcode_sequencer.sv | 146 ++++++++++++++
 tb/tb_microcode_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcseq_pkg.sv
// mcseq_pkg: shared constants, segment table, patch helper and FSM state type
// for the BasicCPU microcode sequencer.
//   OP_W / ADDR_W / N_W : opcode, microcode address and argument word widths
//   OP_*                : opcode field values ([11:8])
//   P*_START / P*_END   : inclusive microcode segment bounds per program
//   P*_MASK             : bits of the immediate field patched from the argument
package mcseq_pkg;

  localparam int unsigned OP_W   = 12;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned N_W    = 9;

  localparam logic [3:0] OP_SET    = 4'b0000;
  localparam logic [3:0] OP_COPY   = 4'b0001;
  localparam logic [3:0] OP_ADD    = 4'b0010;
  localparam logic [3:0] OP_DEC    = 4'b0101;
  localparam logic [3:0] OP_SKIPIF = 4'b1001;

  localparam logic [ADDR_W-1:0] P0_START = 7'd0;
  localparam logic [ADDR_W-1:0] P0_END   = 7'd62;
  localparam logic [ADDR_W-1:0] P1_START = 7'd63;
  localparam logic [ADDR_W-1:0] P1_END   = 7'd91;
  localparam logic [ADDR_W-1:0] P2_START = 7'd92;
  localparam logic [ADDR_W-1:0] P2_END   = 7'd110;

  localparam logic [3:0] P0_MASK = 4'hF;
  localparam logic [3:0] P1_MASK = 4'h7;
  localparam logic [3:0] P2_MASK = 4'h3;

  // Last segment-relative offset patched in program 2 (offsets 1..3).
  localparam logic [ADDR_W-1:0] P2_PATCH_LAST = 7'd3;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StWaitCond,
    StDone
  } state_e;

  function automatic logic [ADDR_W-1:0] seg_start(input logic [1:0] prog);
    logic [ADDR_W-1:0] addr;
    case (prog)
      2'd1:    addr = P1_START;
      2'd2:    addr = P2_START;
      default: addr = P0_START;
    endcase
    return addr;
  endfunction

  function automatic logic [ADDR_W-1:0] seg_end(input logic [1:0] prog);
    logic [ADDR_W-1:0] addr;
    case (prog)
      2'd1:    addr = P1_END;
      2'd2:    addr = P2_END;
      default: addr = P0_END;
    endcase
    return addr;
  endfunction

  // Replace the masked bits of the immediate field with the program's slice of
  // the argument word; all other bits pass through from the store.
  function automatic logic [OP_W-1:0] patch_op(input logic [1:0]        prog,
                                               input logic [ADDR_W-1:0] off,
                                               input logic [N_W-1:0]    n,
                                               input logic [OP_W-1:0]   data);
    logic [3:0] mask;
    logic [3:0] val;
    mask = 4'h0;
    val  = 4'h0;
    case (prog)
      2'd0: begin
        if (off == 7'd1) begin
          mask = P0_MASK;
          val  = n[8:5];
        end
      end
      2'd1: begin
        if (off == 7'd1) begin
          mask = P1_MASK;
          val  = {1'b0, n[4:2]};
        end
      end
      2'd2: begin
        if ((off >= 7'd1) && (off <= P2_PATCH_LAST)) begin
          mask = P2_MASK;
          val  = {2'b00, n[1:0]};
        end
      end
      default: ;
    endcase
    return {data[OP_W-1:4], (data[3:0] & ~mask) | (val & mask)};
  endfunction

endpackage

// File: rtl/microcode_store.sv
// microcode_store: 128 x 12 microcode ROM with synchronous read (1-cycle
// latency). Entries 0..110 hold programs 0..2; unused entries read as zero.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset (clears the output register)
//   i_addr  : read address, sampled on the rising edge
//   o_data  : registered word for the previously presented address
module microcode_store
  import mcseq_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [OP_W-1:0]   o_data
);

  logic [OP_W-1:0] w_word;
  logic [OP_W-1:0] r_data;

  // Bulk of each program is register-mixing ADDs derived from the address;
  // the listed entries are the patch targets, skip-ifs and segment tails.
  always_comb begin
    w_word = '0;
    if (i_addr <= P2_END) begin
      w_word = {OP_ADD, i_addr[3:0], i_addr[6:3]};
    end
    case (i_addr)
      7'd1:   w_word = {OP_SET, 4'hA, 4'h0};
      7'd2:   w_word = {OP_COPY, 4'h1, 4'hA};
      7'd4, 7'd30, 7'd70, 7'd91, 7'd100:
              w_word = {OP_SKIPIF, 4'h3, 4'h0};
      7'd64:  w_word = {OP_SET, 4'hB, 4'h8};
      7'd93:  w_word = {OP_SET, 4'hA, 4'h0};
      7'd94:  w_word = {OP_SET, 4'h1, 4'h0};
      7'd95:  w_word = {OP_SET, 4'h0, 4'h0};
      7'd110: w_word = {OP_DEC, 4'hC, 4'h0};
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= '0;
    end else begin
      r_data <= w_word;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/microcode_sequencer.sv
// microcode_sequencer: steps through one of three microcode programs and
// issues one 12-bit opcode at a time to the datapath over a valid/ready
// stream, patching immediates from the captured argument word and resolving
// skip-if opcodes from the datapath's condition result.
//   i_clk, i_rst_n           : clock, asynchronous active-low reset
//   i_start, i_prog_sel      : start request and program select (3 = invalid)
//   i_n_arg                  : argument word, captured on accepted start
//   o_busy, o_done, o_err    : running flag, end-of-program and bad-select pulses
//   o_op, o_op_valid         : opcode stream to the datapath
//   i_op_ready               : datapath accepts o_op
//   i_cond_valid, i_cond_true: skip-if result from the datapath
// Optional: MCSEQ_SINGLE_STEP_EN adds i_step_en / i_step; with i_step_en high
// each i_step pulse releases exactly one fetch/issue.
module microcode_sequencer
  import mcseq_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [1:0]        i_prog_sel,
  input  logic [N_W-1:0]    i_n_arg,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [OP_W-1:0]   o_op,
  output logic              o_op_valid,
  input  logic              i_op_ready,
  input  logic              i_cond_valid,
  input  logic              i_cond_true
`ifdef MCSEQ_SINGLE_STEP_EN
  ,
  input  logic              i_step_en,
  input  logic              i_step
`endif
);

  state_e            r_state, w_state_next;
  logic [ADDR_W-1:0] r_pc, w_pc_next;
  logic [N_W-1:0]    r_n, w_n_next;
  logic [1:0]        r_prog, w_prog_next;
  logic              r_err, w_err_next;

  logic [OP_W-1:0]   w_rom_data;
  logic [OP_W-1:0]   w_op;
  logic [ADDR_W-1:0] w_seg_end;
  logic [ADDR_W-1:0] w_pc_skip;
  logic              w_fetch_go;

  // ROM address is always the pc: in ISSUE the same word is re-read every
  // cycle, which keeps o_op stable while the datapath stalls.
  microcode_store u_store (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_addr  (r_pc),
    .o_data  (w_rom_data)
  );

`ifdef MCSEQ_SINGLE_STEP_EN
  assign w_fetch_go = !i_step_en || i_step;
`else
  assign w_fetch_go = 1'b1;
`endif

  assign w_seg_end = seg_end(r_prog);
  assign w_op      = patch_op(r_prog, r_pc - seg_start(r_prog), r_n, w_rom_data);
  // Max pc is 110 + 2, so this never wraps in ADDR_W bits.
  assign w_pc_skip = r_pc + (i_cond_true ? 7'd2 : 7'd1);

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_n_next     = r_n;
    w_prog_next  = r_prog;
    w_err_next   = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          if (i_prog_sel == 2'd3) begin
            w_err_next = 1'b1;
          end else begin
            w_n_next     = i_n_arg;
            w_prog_next  = i_prog_sel;
            w_pc_next    = seg_start(i_prog_sel);
            w_state_next = StFetch;
          end
        end
      end
      StFetch: begin
        if (w_fetch_go) begin
          w_state_next = StIssue;
        end
      end
      StIssue: begin
        if (i_op_ready) begin
          if (w_op[11:8] == OP_SKIPIF) begin
            w_state_next = StWaitCond;
          end else if (r_pc == w_seg_end) begin
            w_state_next = StDone;
          end else begin
            w_pc_next    = r_pc + 7'd1;
            w_state_next = StFetch;
          end
        end
      end
      StWaitCond: begin
        if (i_cond_valid) begin
          if (w_pc_skip > w_seg_end) begin
            w_state_next = StDone;
          end else begin
            w_pc_next    = w_pc_skip;
            w_state_next = StFetch;
          end
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_pc    <= '0;
      r_n     <= '0;
      r_prog  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_n     <= w_n_next;
      r_prog  <= w_prog_next;
      r_err   <= w_err_next;
    end
  end

  assign o_op_valid = (r_state == StIssue);
  assign o_op       = o_op_valid ? w_op : '0;
  assign o_busy     = (r_state == StFetch) || (r_state == StIssue) || (r_state == StWaitCond);
  assign o_done     = (r_state == StDone);
  assign o_err      = r_err;

endmodule

// File: tb/tb_microcode_sequencer.sv
module tb_microcode_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  prog_sel;
  logic [8:0]  n_arg;
  logic        busy;
  logic        done;
  logic        err;
  logic [11:0] op;
  logic        op_valid;
  logic        op_ready;
  logic        cond_valid;
  logic        cond_true;
`ifdef MCSEQ_SINGLE_STEP_EN
  logic        step_en;
  logic        step;
`endif

  int checks = 0;
  int errors = 0;
  logic [11:0] got_ops[$];
  int seg_s[3] = '{0, 63, 92};
  int seg_e[3] = '{62, 91, 110};

  microcode_sequencer dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_prog_sel   (prog_sel),
    .i_n_arg      (n_arg),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err),
    .o_op         (op),
    .o_op_valid   (op_valid),
    .i_op_ready   (op_ready),
    .i_cond_valid (cond_valid),
    .i_cond_true  (cond_true)
`ifdef MCSEQ_SINGLE_STEP_EN
    ,
    .i_step_en    (step_en),
    .i_step       (step)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected opcode for an address of a program: store contents plus patching.
  function automatic logic [11:0] ref_op(input int prog, input int addr, input logic [8:0] n);
    logic [6:0]  a;
    logic [11:0] w;
    int          off;
    a   = addr[6:0];
    off = addr - seg_s[prog];
    case (addr)
      1:                   w = 12'h0A0;
      2:                   w = 12'h11A;
      4, 30, 70, 91, 100:  w = 12'h930;
      64:                  w = 12'h0B8;
      93:                  w = 12'h0A0;
      94:                  w = 12'h010;
      95:                  w = 12'h000;
      110:                 w = 12'h5C0;
      default:             w = {4'h2, a[3:0], a[6:3]};
    endcase
    if (prog == 0 && off == 1) w[3:0] = n[8:5];
    if (prog == 1 && off == 1) w[2:0] = n[4:2];
    if (prog == 2 && off >= 1 && off <= 3) w[1:0] = n[1:0];
    return w;
  endfunction

  // Acts as the datapath for one program run, called at a negedge with the
  // DUT idle. cond_mode: 0 false, 1 true, 2 random. rdy_mode: 0 always ready,
  // 1 random ready plus stray start/cond noise, 2 first op stalled 5 cycles.
  // stop_addr >= 0 returns right after the skip-if handshake at that address.
  task automatic run_prog(input int prog, input logic [8:0] n, input int cond_mode,
                          input int rdy_mode, input int stop_addr, input string tag);
    int          m_addr;
    bit          m_done;
    bit          cond_wait;
    int          cond_dly;
    bit          m_cond;
    bit          held;
    logic [11:0] held_op;
    logic [11:0] exp_op;
    int          hold_left;
    bit          finished;
    got_ops.delete();
    start    = 1'b1;
    prog_sel = prog[1:0];
    n_arg    = n;
    op_ready = 1'b0;
    @(negedge clk);
    start     = 1'b0;
    n_arg     = 9'($urandom);
    prog_sel  = 2'($urandom);
    m_addr    = seg_s[prog];
    m_done    = 0;
    cond_wait = 0;
    cond_dly  = 0;
    held      = 0;
    held_op   = '0;
    finished  = 0;
    hold_left = (rdy_mode == 2) ? 5 : 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (done) begin
        finished = 1;
        break;
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy cyc=%0d got=%b exp=1", tag, cyc, busy);
      end
      if (held) begin
        checks++;
        if (op_valid !== 1'b1 || op !== held_op) begin
          errors++;
          $display("FAIL %s stall_hold got valid=%b op=%h exp valid=1 op=%h",
                   tag, op_valid, op, held_op);
        end
      end
      held       = 0;
      cond_valid = 1'b0;
      cond_true  = 1'($urandom);
      if (cond_wait) begin
        checks++;
        if (op_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s valid_in_wait got=%b exp=0", tag, op_valid);
        end
        if (cond_dly == 0) begin
          m_cond     = (cond_mode == 0) ? 1'b0 : (cond_mode == 1) ? 1'b1 : 1'($urandom);
          cond_valid = 1'b1;
          cond_true  = m_cond;
          cond_wait  = 0;
          m_addr     = m_addr + (m_cond ? 2 : 1);
          if (m_addr > seg_e[prog]) m_done = 1;
        end else begin
          cond_dly--;
        end
      end else if (rdy_mode == 1) begin
        cond_valid = ($urandom_range(3, 0) == 0);
      end
      if (rdy_mode == 1) begin
        start    = ($urandom_range(7, 0) == 0);
        prog_sel = 2'($urandom);
      end
      if (op_valid === 1'b1) begin
        exp_op = ref_op(prog, m_addr, n);
        checks++;
        if (m_done || op !== exp_op) begin
          errors++;
          $display("FAIL %s op addr=%0d ended=%0d got=%h exp=%h", tag, m_addr, m_done, op, exp_op);
        end
        if (hold_left > 0) begin
          op_ready = 1'b0;
          hold_left--;
        end else begin
          op_ready = (rdy_mode == 1) ? 1'($urandom) : 1'b1;
        end
        if (op_ready) begin
          got_ops.push_back(op);
          if (exp_op[11:8] == 4'b1001) begin
            cond_wait = 1;
            cond_dly  = $urandom_range(2, 0);
            if (m_addr == stop_addr) begin
              start      = 1'b0;
              cond_valid = 1'b0;
              return;
            end
          end else if (m_addr == seg_e[prog]) begin
            m_done = 1;
          end else begin
            m_addr++;
          end
        end else begin
          held    = 1;
          held_op = op;
        end
      end else begin
        op_ready = 1'($urandom);
      end
      @(negedge clk);
    end
    start      = 1'b0;
    cond_valid = 1'b0;
    op_ready   = 1'b0;
    checks++;
    if (!finished || !m_done) begin
      errors++;
      $display("FAIL %s done_timing got done=%0d exp program_end=%0d", tag, finished, m_done);
    end
    checks++;
    if (busy !== 1'b0 || op_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s done_state got busy=%b valid=%b exp 0 0", tag, busy, op_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse got done=%b busy=%b exp 0 0", tag, done, busy);
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    start      = 1'b0;
    prog_sel   = 2'd0;
    n_arg      = '0;
    op_ready   = 1'b0;
    cond_valid = 1'b0;
    cond_true  = 1'b0;
`ifdef MCSEQ_SINGLE_STEP_EN
    step_en    = 1'b0;
    step       = 1'b0;
`endif
    #12;
    checks++;
    if ({busy, done, err, op_valid} !== 4'b0 || op !== 12'h000) begin
      errors++;
      $display("FAIL reset got busy=%b done=%b err=%b valid=%b op=%h exp all 0",
               busy, done, err, op_valid, op);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_err();
    start    = 1'b1;
    prog_sel = 2'd3;
    n_arg    = 9'($urandom);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse got err=%b busy=%b exp 1 0", err, busy);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got err=%b busy=%b exp 0 0", err, busy);
    end
  endtask

  task automatic test_p0_patch();
    run_prog(0, 9'b0101_00000, 0, 0, -1, "p0_patch");
    checks++;
    if (got_ops.size() != 63 || got_ops[1] !== 12'h0A5 || got_ops[5] !== 12'h250) begin
      errors++;
      $display("FAIL p0_patch got n=%0d op1=%h op5=%h exp n=63 op1=0a5 op5=250",
               got_ops.size(), got_ops[1], got_ops[5]);
    end
  endtask

  task automatic test_p2_patch();
    run_prog(2, 9'b0000000_11, 2, 0, -1, "p2_patch");
    checks++;
    if (got_ops.size() < 4 || got_ops[1] !== 12'h0A3 || got_ops[2] !== 12'h013 ||
        got_ops[3] !== 12'h003) begin
      errors++;
      $display("FAIL p2_patch got %h %h %h exp 0a3 013 003", got_ops[1], got_ops[2], got_ops[3]);
    end
  endtask

  task automatic test_skip();
    run_prog(0, 9'($urandom), 1, 0, -1, "skip_true");
    checks++;
    if (got_ops.size() != 61 || got_ops[4] !== 12'h930 || got_ops[5] !== 12'h260) begin
      errors++;
      $display("FAIL skip_true got n=%0d op4=%h op5=%h exp n=61 op4=930 op5=260",
               got_ops.size(), got_ops[4], got_ops[5]);
    end
  endtask

  task automatic test_skip_at_end();
    run_prog(1, 9'($urandom), 1, 0, -1, "skip_end");
    checks++;
    if (got_ops.size() != 28 || got_ops[got_ops.size()-1] !== 12'h930) begin
      errors++;
      $display("FAIL skip_end got n=%0d last=%h exp n=28 last=930",
               got_ops.size(), got_ops[got_ops.size()-1]);
    end
  endtask

  task automatic test_stall();
    run_prog(0, 9'($urandom), 2, 2, -1, "stall");
  endtask

  task automatic test_reset_mid_p1();
    run_prog(1, 9'($urandom), 0, 0, 70, "rst_mid");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, op_valid} !== 4'b0 || op !== 12'h000) begin
      errors++;
      $display("FAIL rst_mid_outputs got busy=%b done=%b err=%b valid=%b op=%h exp all 0",
               busy, done, err, op_valid, op);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_hold got done=%b busy=%b exp 0 0", done, busy);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_prog(1, 9'($urandom), 2, 1, -1, "rst_restart");
    checks++;
    if (got_ops.size() == 0 || got_ops[0] !== 12'h2F7) begin
      errors++;
      $display("FAIL rst_restart_first got=%h exp=2f7", got_ops[0]);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      run_prog($urandom_range(2, 0), 9'($urandom), 2, 1, -1, "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_err();
    test_p0_patch();
    test_p2_patch();
    test_skip();
    test_skip_at_end();
    test_stall();
    test_reset_mid_p1();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
